// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: drives datapath selects and enables
// from the current state, opcode, funct, zero flag and memready.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       half,
  output logic       b,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t cur, nxt;
  logic   mem_ok;
  logic   is_lw, is_lh, is_lb, is_sw;
  logic   is_r, is_beq, is_bne, is_addi, is_j;
  logic   is_mem, is_br;

  assign mem_ok  = MEM_HANDSHAKE ? memready : 1'b1;

  assign is_lw   = (op == 6'b100011);
  assign is_lh   = (op == 6'b100001);
  assign is_lb   = (op == 6'b100000);
  assign is_sw   = (op == 6'b101011);
  assign is_r    = (op == 6'b000000);
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_addi = (op == 6'b001000);
  assign is_j    = (op == 6'b000010);
  assign is_mem  = is_lw | is_lh | is_lb | is_sw;
  assign is_br   = is_beq | is_bne;

  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt        = FETCH;
    pcen       = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    half       = 1'b0;
    b          = 1'b0;
    illegal    = 1'b0;
    unique case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ok;
        pcen    = mem_ok;
        nxt     = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        // branch target is precomputed into ALUOut here
        alusrcb = 2'b11;
        unique case (1'b1)
          is_mem:  nxt = MEMADR;
          is_r:    nxt = EXECUTE;
          is_br:   nxt = BRANCH;
          is_addi: nxt = ADDIEX;
          is_j:    nxt = JUMP;
          default: begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        half = is_lh;
        b    = is_lb;
        nxt  = mem_ok ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        half     = is_lh;
        b        = is_lb;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        nxt      = mem_ok ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
        nxt = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero ^ is_bne;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: one row per clock,
// outputs sampled 1ns after the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memready = 1'b1;
  logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite;
  logic       alusrca, half, b, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .half(half), .b(b),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_LW = 6'b100011, OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000, OP_SW = 6'b101011;
  localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

  // bit order: pcen iord irw mw m2r rd rw asa asb[2] pcs[2] alu[3] h b ill
  localparam logic [17:0] C_ALL = 18'h3FFFF;
  localparam logic [17:0] C_EN = 18'h2C807;
  localparam logic [17:0] C_IORD = 18'h10000;
  localparam logic [17:0] C_WB = 18'h03000;
  localparam logic [17:0] C_ALU = 18'h00738;
  localparam logic [17:0] C_PCS = 18'h000C0;

  function automatic logic [17:0] pk(
    input logic pc, io, irw, mw, m2r, rd, rw, asa,
    input logic [1:0] asb, pcs, input logic [2:0] alu,
    input logic h, bb, ill);
    return {pc, io, irw, mw, m2r, rd, rw, asa, asb, pcs, alu, h, bb, ill};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] exp;
    logic [17:0] care;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic r, input logic [5:0] o, f,
                     input logic z, mr, input logic [3:0] st,
                     input logic [17:0] e, c);
    vec_t v;
    v.rst = r; v.op = o; v.fn = f; v.z = z; v.mr = mr;
    v.st = st; v.exp = e; v.care = c;
    vq.push_back(v);
  endtask

  logic [17:0] e_f1, e_f0, e_dec, e_ill, e_adr, e_rd, e_rdh, e_rdb;
  logic [17:0] e_wb, e_wbh, e_wbb, e_wr, e_ex_slt, e_ex_or, e_ex_add;
  logic [17:0] e_awb, e_brt, e_brn, e_aex, e_iwb, e_jmp;
  logic [17:0] c_f, c_alu, c_io, c_wb, c_br, c_jmp, got;

  initial begin
    e_f1  = pk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    e_f0  = pk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    e_dec = pk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,0);
    e_ill = pk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,1);
    e_adr = pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    e_rd  = pk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    e_rdh = pk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,0,0);
    e_rdb = pk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1,0);
    e_wb  = pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0,0);
    e_wbh = pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,1,0,0);
    e_wbb = pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,1,0);
    e_wr  = pk(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    e_ex_slt = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0,0);
    e_ex_or  = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0,0,0);
    e_ex_add = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,0,0);
    e_awb = pk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0,0);
    e_brt = pk(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,0);
    e_brn = pk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,0);
    e_aex = pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    e_iwb = pk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0,0);
    e_jmp = pk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0,0);
    c_f = C_ALL;
    c_alu = C_EN | C_ALU;
    c_io = C_EN | C_IORD;
    c_wb = C_EN | C_WB;
    c_br = C_EN | C_ALU | C_PCS;
    c_jmp = C_EN | C_PCS;

    // reset held 3 cycles, then lw with two memready-low cycles in MEMRD
    repeat (3) add(1, OP_LW, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_LW, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_LW, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_LW, 0, 0, 1, 2, e_adr, c_alu);
    add(0, OP_LW, 0, 0, 0, 3, e_rd, c_io);
    add(0, OP_LW, 0, 0, 0, 3, e_rd, c_io);
    add(0, OP_LW, 0, 0, 1, 3, e_rd, c_io);
    add(0, OP_LW, 0, 0, 1, 4, e_wb, c_wb);
    // fetch stall, then lb
    add(0, OP_LB, 0, 0, 0, 0, e_f0, c_f);
    add(0, OP_LB, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_LB, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_LB, 0, 0, 1, 2, e_adr, c_alu);
    add(0, OP_LB, 0, 0, 1, 3, e_rdb, c_io);
    add(0, OP_LB, 0, 0, 1, 4, e_wbb, c_wb);
    // lh
    add(0, OP_LH, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_LH, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_LH, 0, 0, 1, 2, e_adr, c_alu);
    add(0, OP_LH, 0, 0, 1, 3, e_rdh, c_io);
    add(0, OP_LH, 0, 0, 1, 4, e_wbh, c_wb);
    // beq/bne with zero=1 then zero=0
    add(0, OP_BEQ, 0, 1, 1, 0, e_f1, c_f);
    add(0, OP_BEQ, 0, 1, 1, 1, e_dec, c_alu);
    add(0, OP_BEQ, 0, 1, 1, 8, e_brt, c_br);
    add(0, OP_BNE, 0, 1, 1, 0, e_f1, c_f);
    add(0, OP_BNE, 0, 1, 1, 1, e_dec, c_alu);
    add(0, OP_BNE, 0, 1, 1, 8, e_brn, c_br);
    add(0, OP_BEQ, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_BEQ, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_BEQ, 0, 0, 1, 8, e_brn, c_br);
    add(0, OP_BNE, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_BNE, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_BNE, 0, 0, 1, 8, e_brt, c_br);
    // R-type slt, or, and an unknown funct
    add(0, OP_R, 6'b101010, 0, 1, 0, e_f1, c_f);
    add(0, OP_R, 6'b101010, 0, 1, 1, e_dec, c_alu);
    add(0, OP_R, 6'b101010, 0, 1, 6, e_ex_slt, c_alu);
    add(0, OP_R, 6'b101010, 0, 1, 7, e_awb, c_wb);
    add(0, OP_R, 6'b100101, 0, 1, 0, e_f1, c_f);
    add(0, OP_R, 6'b100101, 0, 1, 1, e_dec, c_alu);
    add(0, OP_R, 6'b100101, 0, 1, 6, e_ex_or, c_alu);
    add(0, OP_R, 6'b100101, 0, 1, 7, e_awb, c_wb);
    add(0, OP_R, 6'b111111, 0, 1, 0, e_f1, c_f);
    add(0, OP_R, 6'b111111, 0, 1, 1, e_dec, c_alu);
    add(0, OP_R, 6'b111111, 0, 1, 6, e_ex_add, c_alu);
    add(0, OP_R, 6'b111111, 0, 1, 7, e_awb, c_wb);
    // illegal opcode: one-cycle pulse, straight back to fetch
    add(0, OP_BAD, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_BAD, 0, 0, 1, 1, e_ill, c_alu);
    add(0, OP_ADDI, 0, 0, 1, 0, e_f1, c_f);
    // addi, then j
    add(0, OP_ADDI, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_ADDI, 0, 0, 1, 9, e_aex, c_alu);
    add(0, OP_ADDI, 0, 0, 1, 10, e_iwb, c_wb);
    add(0, OP_J, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_J, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_J, 0, 0, 1, 11, e_jmp, c_jmp);
    // sw with completing write, then sw aborted by reset while stalled
    add(0, OP_SW, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_SW, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_SW, 0, 0, 1, 2, e_adr, c_alu);
    add(0, OP_SW, 0, 0, 1, 5, e_wr, c_io);
    add(0, OP_SW, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_SW, 0, 0, 1, 1, e_dec, c_alu);
    add(0, OP_SW, 0, 0, 1, 2, e_adr, c_alu);
    add(0, OP_SW, 0, 0, 0, 5, e_wr, c_io);
    add(1, OP_SW, 0, 0, 0, 0, e_f0, c_f);
    add(0, OP_SW, 0, 0, 1, 0, e_f1, c_f);
    add(0, OP_SW, 0, 0, 1, 1, e_dec, c_alu);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst;
      op = vq[i].op;
      funct = vq[i].fn;
      zero = vq[i].z;
      memready = vq[i].mr;
      #1;
      got = {pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, half, b, illegal};
      checks++;
      if (state !== vq[i].st) begin
        failures++;
        $display("FAIL row%0d state: got %0d want %0d",
                 i, state, vq[i].st);
      end
      checks++;
      if (((got ^ vq[i].exp) & vq[i].care) !== 18'h0) begin
        failures++;
        $display("FAIL row%0d outputs: got %b want %b care %b",
                 i, got, vq[i].exp, vq[i].care);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
